// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared encodings for the LED port arbiter.
//   arb_state_e  - arbiter FSM states
//   owner_e      - OWNER output codes
//   last_owner_e - side that most recently held a normal grant (tie-break)
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_S = 2'd1,
    GNT_I = 2'd2,
    FORCE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_SPI  = 2'b01,
    OWN_I2C  = 2'b10,
    OWN_OVR  = 2'b11
  } owner_e;

  typedef enum logic {
    LAST_SPI = 1'b0,
    LAST_I2C = 1'b1
  } last_owner_e;

endpackage

// File: rtl/led_port_arbiter_if.sv
// led_port_arbiter_if: requester-side bus of the LED port arbiter.
//   SPI_REQ/SPI_DATA  - SPI request and LED pattern (requester -> arbiter)
//   I2C_REQ/I2C_DATA  - I2C request and LED pattern (requester -> arbiter)
//   OVR_BTN           - raw override push-button (requester -> arbiter)
//   GNT_SPI/GNT_I2C   - ownership grants (arbiter -> requester)
//   LED               - registered LED drive (arbiter -> board)
//   OWNER             - current owner code (arbiter -> requester)
// modport master: requester/board side; modport slave: the arbiter.
interface led_port_arbiter_if;
  logic       SPI_REQ;
  logic [7:0] SPI_DATA;
  logic       I2C_REQ;
  logic [7:0] I2C_DATA;
  logic       OVR_BTN;
  logic       GNT_SPI;
  logic       GNT_I2C;
  logic [7:0] LED;
  logic [1:0] OWNER;

  modport master (
    output SPI_REQ, SPI_DATA, I2C_REQ, I2C_DATA, OVR_BTN,
    input  GNT_SPI, GNT_I2C, LED, OWNER
  );

  modport slave (
    input  SPI_REQ, SPI_DATA, I2C_REQ, I2C_DATA, OVR_BTN,
    output GNT_SPI, GNT_I2C, LED, OWNER
  );
endinterface

// File: rtl/led_port_arbiter_btn_debounce.sv
// btn_debounce: 2-flop synchroniser for the override button, followed by an
// optional debouncer when LED_ARB_DEBOUNCE_EN is defined.
//   clk    - PCLK
//   rst_n  - asynchronous active-low reset
//   btn_i  - raw button, asynchronous to clk
//   ovr_o  - synchronised (and optionally debounced) override level
// With LED_ARB_DEBOUNCE_EN, ovr_o changes only after DEBOUNCE_CYCLES
// consecutive synchronised samples that differ from the current ovr_o.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic ovr_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

`ifdef LED_ARB_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;

  // Counter tracks how many consecutive samples disagree with ovr_q; any
  // agreeing sample restarts it.
  always_comb begin
    cnt_d = '0;
    ovr_d = ovr_q;
    if (sync_q[1] != ovr_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ovr_d = sync_q[1];
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  assign ovr_o = ovr_q;
`else
  assign ovr_o = sync_q[1];
`endif

endmodule

// File: rtl/led_port_arbiter.sv
// led_port_arbiter: shares the 8-bit LED port between the SPI slave and the
// I2C port-expander with round-robin fairness and a minimum tenure.
//   PCLK     - clock, all state on rising edge
//   RESET_n  - asynchronous active-low reset
//   bus      - led_port_arbiter_if.slave (requests, patterns, override
//              button in; grants, LED, OWNER out)
// Parameters: HOLD_CYCLES (min tenure / max tenure when contested),
// DEBOUNCE_CYCLES (override debounce, used with LED_ARB_DEBOUNCE_EN).
// Optional feature macro: LED_ARB_DEBOUNCE_EN (see btn_debounce).
import led_arb_pkg::*;

module led_port_arbiter #(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                PCLK,
  input  logic                RESET_n,
  led_port_arbiter_if.slave   bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  logic [1:0]  spi_sync_q, i2c_sync_q;
  logic        sreq_s, sreq_i, ovr;

  arb_state_e  state_q, state_d;
  last_owner_e last_q, last_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  led_q, led_d;
  logic        hold_expired;

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      spi_sync_q <= '0;
      i2c_sync_q <= '0;
    end else begin
      spi_sync_q <= {spi_sync_q[0], bus.SPI_REQ};
      i2c_sync_q <= {i2c_sync_q[0], bus.I2C_REQ};
    end
  end

  assign sreq_s = spi_sync_q[1];
  assign sreq_i = i2c_sync_q[1];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (PCLK),
    .rst_n (RESET_n),
    .btn_i (bus.OVR_BTN),
    .ovr_o (ovr)
  );

  // State register (also holds tenure counter, tie-break memory and LED).
  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_I2C;
      hold_cnt_q <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
    end
  end

  assign hold_expired = (hold_cnt_q == '0);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    led_d      = led_q;
    hold_cnt_d = hold_expired ? hold_cnt_q : hold_cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (ovr)                                        state_d = FORCE;
        else if (sreq_s && (!sreq_i || last_q == LAST_I2C)) state_d = GNT_S;
        else if (sreq_i)                                state_d = GNT_I;
      end
      GNT_S: begin
        if (ovr)                           state_d = FORCE;
        else if (hold_expired && sreq_i)   state_d = GNT_I;
        else if (hold_expired && !sreq_s)  state_d = IDLE;
      end
      GNT_I: begin
        if (ovr)                           state_d = FORCE;
        else if (hold_expired && sreq_s)   state_d = GNT_S;
        else if (hold_expired && !sreq_i)  state_d = IDLE;
      end
      FORCE: begin
        if (!ovr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering a normal grant (from IDLE or a direct handover) starts a
    // fresh tenure; FORCE leaves last_q alone.
    if (state_d != state_q) begin
      if (state_d == GNT_S) begin
        hold_cnt_d = HOLD_MAX;
        last_d     = LAST_SPI;
      end else if (state_d == GNT_I) begin
        hold_cnt_d = HOLD_MAX;
        last_d     = LAST_I2C;
      end
    end

    // Loading from the next state puts DATA on LED on the granting edge.
    case (state_d)
      GNT_S:        led_d = bus.SPI_DATA;
      GNT_I, FORCE: led_d = bus.I2C_DATA;
      default:      led_d = led_q;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.GNT_SPI = 1'b0;
    bus.GNT_I2C = 1'b0;
    bus.OWNER   = OWN_NONE;
    case (state_q)
      GNT_S: begin
        bus.GNT_SPI = 1'b1;
        bus.OWNER   = OWN_SPI;
      end
      GNT_I: begin
        bus.GNT_I2C = 1'b1;
        bus.OWNER   = OWN_I2C;
      end
      FORCE: begin
        bus.GNT_I2C = 1'b1;
        bus.OWNER   = OWN_OVR;
      end
      default: ;
    endcase
  end

  assign bus.LED = led_q;

endmodule

// File: tb/tb_led_port_arbiter.sv
// tb_led_port_arbiter: self-checking bench for led_port_arbiter with a
// behavioural ownership model (owner / tenure age / delayed request samples).
module tb_led_port_arbiter;

  localparam int HOLD = 16;
  localparam int DEB  = 1024;

  logic PCLK = 1'b0;
  logic RESET_n;

  led_port_arbiter_if bus();

  led_port_arbiter #(
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .PCLK    (PCLK),
    .RESET_n (RESET_n),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner 0 none, 1 SPI, 2 I2C, 3 override.
  int         m_own, m_age, m_last, m_dcnt;
  logic [7:0] m_led;
  bit   [1:0] m_ss, m_si, m_so;
  bit         m_ovr;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_age = 0; m_last = 2; m_dcnt = 0;
    m_led = 8'h00; m_ss = '0; m_si = '0; m_so = '0; m_ovr = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using inputs present at the edge.
  task automatic model_edge();
    bit s, i, o, expired, mine, other;
    int nxt;
    s = m_ss[1];
    i = m_si[1];
`ifdef LED_ARB_DEBOUNCE_EN
    o = m_ovr;
`else
    o = m_so[1];
`endif
    expired = (m_age >= HOLD - 1);
    nxt = m_own;
    mine  = (m_own == 1) ? s : i;
    other = (m_own == 1) ? i : s;
    case (m_own)
      0: begin
        if (o)           nxt = 3;
        else if (s && i) nxt = (m_last == 2) ? 1 : 2;
        else if (s)      nxt = 1;
        else if (i)      nxt = 2;
      end
      1, 2: begin
        if (o)                     nxt = 3;
        else if (expired && other) nxt = 3 - m_own;
        else if (expired && !mine) nxt = 0;
      end
      default: if (!o) nxt = 0;
    endcase
    if ((nxt == 1 || nxt == 2) && nxt != m_own) begin
      m_age  = 0;
      m_last = nxt;
    end else begin
      m_age++;
    end
    if (nxt == 1)      m_led = bus.SPI_DATA;
    else if (nxt >= 2) m_led = bus.I2C_DATA;
    m_own = nxt;
`ifdef LED_ARB_DEBOUNCE_EN
    if (m_so[1] != m_ovr) begin
      m_dcnt++;
      if (m_dcnt == DEB) begin
        m_ovr  = m_so[1];
        m_dcnt = 0;
      end
    end else begin
      m_dcnt = 0;
    end
`endif
    m_ss = {m_ss[0], bus.SPI_REQ};
    m_si = {m_si[0], bus.I2C_REQ};
    m_so = {m_so[0], bus.OVR_BTN};
  endtask

  task automatic check_model();
    chk("gnt_spi", {7'b0, bus.GNT_SPI}, {7'b0, (m_own == 1)});
    chk("gnt_i2c", {7'b0, bus.GNT_I2C}, {7'b0, (m_own >= 2)});
    chk("led",     bus.LED,             m_led);
    chk("owner",   {6'b0, bus.OWNER},   8'(m_own));
  endtask

  task automatic tick();
    @(posedge PCLK);
    if (!RESET_n) model_reset();
    else          model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_owner(input logic [1:0] exp, input int max_cycles, input string tag);
    for (int k = 0; k < max_cycles; k++) begin
      if (bus.OWNER === exp) break;
      tick();
    end
    chk(tag, {6'b0, bus.OWNER}, {6'b0, exp});
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_gs"},  {7'b0, bus.GNT_SPI}, 8'h00);
    chk({tag, "_gi"},  {7'b0, bus.GNT_I2C}, 8'h00);
    chk({tag, "_led"}, bus.LED, 8'h00);
    chk({tag, "_own"}, {6'b0, bus.OWNER}, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ovr;
    RESET_n = 1'b0;
    bus.SPI_REQ = 1'b0; bus.SPI_DATA = 8'h00;
    bus.I2C_REQ = 1'b0; bus.I2C_DATA = 8'h00;
    bus.OVR_BTN = 1'b0;
    model_reset();
    repeat (3) tick();
    chk_cleared("reset");
    RESET_n = 1'b1;

    // Single request: grant on 3rd edge, then release after tenure.
    bus.SPI_DATA = 8'hA5;
    bus.SPI_REQ  = 1'b1;
    tick(); tick();
    chk("t1_pre_gnt", {7'b0, bus.GNT_SPI}, 8'h00);
    tick();
    chk("t1_gnt", {7'b0, bus.GNT_SPI}, 8'h01);
    chk("t1_led", bus.LED, 8'hA5);
    chk("t1_own", {6'b0, bus.OWNER}, 8'h01);
    repeat (16) tick();
    bus.SPI_REQ = 1'b0;
    repeat (4) tick();
    chk("t1_rel_gs", {7'b0, bus.GNT_SPI}, 8'h00);
    chk("t1_rel_gi", {7'b0, bus.GNT_I2C}, 8'h00);
    chk("t1_rel_led", bus.LED, 8'hA5);

    // Tie after reset: SPI first, direct handover after HOLD cycles.
    #2 RESET_n = 1'b0;
    model_reset();
    #1 chk_cleared("t2_rst");
    tick();
    RESET_n = 1'b1;
    bus.SPI_DATA = 8'h11; bus.I2C_DATA = 8'h5A;
    bus.SPI_REQ = 1'b1;   bus.I2C_REQ = 1'b1;
    repeat (3) tick();
    chk("t2_spi_first", {7'b0, bus.GNT_SPI}, 8'h01);
    repeat (HOLD - 1) tick();
    chk("t2_spi_last", {7'b0, bus.GNT_SPI}, 8'h01);
    tick();
    chk("t2_hand_gi", {7'b0, bus.GNT_I2C}, 8'h01);
    chk("t2_hand_gs", {7'b0, bus.GNT_SPI}, 8'h00);
    chk("t2_hand_led", bus.LED, 8'h5A);

    // Early drop: I2C keeps its grant until tenure expiry.
    bus.SPI_REQ = 1'b0;
    repeat (3) tick();
    bus.I2C_REQ = 1'b0;
    repeat (2) tick();
    bus.I2C_DATA = 8'h77;
    repeat (9) tick();
    tick();
    chk("t3_held", {7'b0, bus.GNT_I2C}, 8'h01);
    chk("t3_led", bus.LED, 8'h77);
    tick();
    chk("t3_idle", {6'b0, bus.OWNER}, 8'h00);

    // Override while SPI owns the port.
    bus.SPI_DATA = 8'hC3; bus.I2C_DATA = 8'h3C;
    bus.SPI_REQ  = 1'b1;
    wait_owner(2'b01, 6, "t4_spi");
    bus.OVR_BTN = 1'b1;
    wait_owner(2'b11, DEB + 10, "t4_force");
    chk("t4_led", bus.LED, 8'h3C);
    chk("t4_gi", {7'b0, bus.GNT_I2C}, 8'h01);
    bus.OVR_BTN = 1'b0;
    wait_owner(2'b00, DEB + 10, "t4_idle");
    wait_owner(2'b01, 6, "t4_regrant");
    bus.SPI_REQ = 1'b0;
    repeat (25) tick();

`ifdef LED_ARB_DEBOUNCE_EN
    // Short glitches never reach FORCE; a long press does.
    saw_ovr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      bus.OVR_BTN = 1'b1;
      repeat ($urandom_range(20, DEB - 100)) begin
        tick();
        if (bus.OWNER === 2'b11) saw_ovr = 1'b1;
      end
      bus.OVR_BTN = 1'b0;
      repeat (30) begin
        tick();
        if (bus.OWNER === 2'b11) saw_ovr = 1'b1;
      end
    end
    chk("deb_glitch", {7'b0, saw_ovr}, 8'h00);
    bus.OVR_BTN = 1'b1;
    wait_owner(2'b11, 1100, "deb_press");
    bus.OVR_BTN = 1'b0;
    wait_owner(2'b00, 1100, "deb_release");
`else
    saw_ovr = 1'b0;
`endif

    // Reset mid-tenure during GNT_I clears asynchronously.
    bus.I2C_DATA = 8'h96;
    bus.I2C_REQ  = 1'b1;
    wait_owner(2'b10, 6, "t5_i2c");
    repeat (4) tick();
    #3 RESET_n = 1'b0;
    model_reset();
    #1 chk_cleared("t5_async");
    bus.SPI_REQ = 1'b1;
    tick(); tick();
    RESET_n = 1'b1;
    wait_owner(2'b01, 6, "t5_tie_spi");
    bus.SPI_REQ = 1'b0; bus.I2C_REQ = 1'b0;
    repeat (40) tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) bus.SPI_REQ = ~bus.SPI_REQ;
      if ($urandom_range(0, 9) == 0) bus.I2C_REQ = ~bus.I2C_REQ;
      if ($urandom_range(0, 3) == 0) bus.SPI_DATA = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.I2C_DATA = 8'($urandom);
      if ($urandom_range(0, 59) == 0) bus.OVR_BTN = ~bus.OVR_BTN;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_port_arbiter.md
# led_port_arbiter

Shares the 8-bit LED port between the SPI slave and the I2C port-expander, replacing the static LED mux in the CPLD top level. Each requester raises a request and presents its LED pattern; the arbiter synchronises requests into PCLK, grants ownership with round-robin fairness and a minimum tenure, and registers the owner's pattern onto LED. A debounced push-button override forces I2C ownership for bench use.

## Interface
- HOLD_CYCLES, 16: minimum tenure in PCLK cycles; also the maximum tenure while the other side is waiting.
- DEBOUNCE_CYCLES, 1024: number of cycles OVR_BTN must be stable before a change is accepted. Used only with the debounce option.
- PCLK  input  1  clock; all state on rising edge.
- RESET_n  input  1  asynchronous, active-low reset.
- SPI_REQ  input  1  SPI side wants LED port. Asynchronous to PCLK.
- SPI_DATA  input  8  SPI LED pattern. Quasi-static while SPI_REQ is high.
- I2C_REQ  input  1  I2C side wants LED port. Asynchronous to PCLK.
- I2C_DATA  input  8  I2C LED pattern. Quasi-static while I2C_REQ is high.
- OVR_BTN  input  1  raw override button, active-high.
- GNT_SPI  output  1  SPI owns port.
- GNT_I2C  output  1  I2C owns port.
- LED  output  8  registered LED drive.
- OWNER  output  2  00 none, 01 SPI, 10 I2C, 11 override.

## Operation
- SPI_REQ, I2C_REQ and OVR_BTN each pass through a 2-flop synchroniser; the synchronised values are sreq_s, sreq_i and ovr.
- States: IDLE, GNT_S, GNT_I, FORCE.
- IDLE:
  - ovr → FORCE.
  - Only sreq_s → GNT_S; only sreq_i → GNT_I.
  - Both high → the side that is not last_owner wins.
  - last_owner resets to I2C, so SPI wins the first tie.
- Entering GNT_S or GNT_I: load hold_cnt with HOLD_CYCLES-1 and update last_owner.
- In GNT_x, hold_cnt decrements to 0 and saturates there. Priority order:
  1. ovr → FORCE.
  2. hold_cnt==0 and the other request is high → go directly to the other GNT state. The grant switches in one cycle; the two grants are never high together.
  3. hold_cnt==0 and own request low → IDLE.
  4. Otherwise stay.
- A request dropped before hold_cnt reaches 0 keeps the grant until expiry. LED keeps following that requester's DATA during this time.
- FORCE: GNT_I2C=1, GNT_SPI=0, LED follows I2C_DATA. When ovr goes low → IDLE; last_owner is unchanged.
- LED is loaded with the owner's DATA every cycle a grant is active. In IDLE, LED holds its last value.
- hold_cnt width: $clog2(HOLD_CYCLES).

## Timing
- Reset values: GNT_SPI=0, GNT_I2C=0, LED=8'h00, OWNER=00, state IDLE, last_owner=I2C, hold_cnt=0.
- Reset is asynchronous and clears everything mid-tenure. After release the block starts in IDLE.
- Request to grant: 3 PCLK edges (2 synchroniser stages plus state register).
- Grant to LED: LED reflects DATA on the same edge that asserts GNT. After that, DATA changes appear on LED one cycle later.
- Release to re-grant through IDLE: at least one cycle with both grants low.
- Contested handover happens exactly HOLD_CYCLES cycles after the grant edge.
- Override is recognised 2 cycles after OVR_BTN changes, plus debounce time when the debounce option is built.

## Configuration
- LED_ARB_DEBOUNCE_EN defined:
  - The synchronised OVR_BTN feeds a debouncer.
  - ovr changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES) bits and resets to 0; ovr resets to 0.
- LED_ARB_DEBOUNCE_EN undefined: ovr is the synchroniser output directly, with no counter logic.

## Structure
- Package led_arb_pkg holds:
  - state encoding IDLE/GNT_S/GNT_I/FORCE;
  - OWNER codes OWN_NONE/OWN_SPI/OWN_I2C/OWN_OVR;
  - last-owner encoding.
- Sub-module btn_debounce contains the synchroniser plus the optional debounce counter for OVR_BTN.
- Request synchronisers and the FSM stay in led_port_arbiter.

## Test plan
- Single request:
  - Stimulus: RESET_n released; SPI_REQ=1, SPI_DATA=8'hA5.
  - Response: GNT_SPI=1, LED=8'hA5 and OWNER=01 on the 3rd edge. When SPI_REQ drops after HOLD_CYCLES, both grants go low and LED holds 8'hA5.
- Tie:
  - Stimulus: after reset, SPI_REQ and I2C_REQ rise on the same edge.
  - Response: SPI is granted first. At HOLD_CYCLES=16 the grant passes directly to I2C, with no overlap and no idle cycle.
- Early drop:
  - Stimulus: I2C granted, I2C_REQ drops at cycle 3 of tenure.
  - Response: GNT_I2C stays high until cycle 16, then IDLE.
- Override:
  - Stimulus: while SPI is granted, assert OVR_BTN.
  - Response: FORCE, OWNER=11, LED follows I2C_DATA=8'h3C. When the button is released → IDLE, then SPI is re-granted because SPI_REQ is still high.
- Debounce (LED_ARB_DEBOUNCE_EN):
  - Stimulus: OVR_BTN pulses shorter than DEBOUNCE_CYCLES.
  - Response: OWNER never becomes 11.
  - Stimulus: a stable 1100-cycle press.
  - Response: FORCE is entered.
- Reset mid-tenure:
  - Stimulus: assert RESET_n low during GNT_I.
  - Response: all outputs clear asynchronously to reset values; the next tie goes to SPI.
